// File: rtl/trig_coax_tx_if.sv
// Trigger-side bundle of trig_coax_tx: requests, enables and calibration control in,
// coax drive, status and the sent-pulse counter readout out.
interface trig_coax_tx_if #(
    parameter int NCH = 16
);
    logic [NCH-1:0] trig_in;
    logic [NCH-1:0] ch_en;
    logic           cal_start;
    logic [3:0]     cnt_sel;
    logic           cnt_clr;
    logic [NCH-1:0] coax_out;
    logic           cal_busy;
    logic [1:0]     phase;
    logic [15:0]    cnt_out;

    modport master (
        output trig_in, ch_en, cal_start, cnt_sel, cnt_clr,
        input  coax_out, cal_busy, phase, cnt_out
    );

    modport slave (
        input  trig_in, ch_en, cal_start, cnt_sel, cnt_clr,
        output coax_out, cal_busy, phase, cnt_out
    );
endinterface

// File: rtl/trig_coax_tx.sv
// Coax trigger transmitter: slot-quantised trigger pulses plus quiet/sync/guard calibration burst.
// Optional per-channel sent-pulse counters are built when TRIGTX_COUNT_EN is defined.
module trig_coax_tx #(
    parameter int NCH         = 16,
    parameter int QUIET_TICKS = 250,
    parameter int NSYNC       = 55,
    parameter int GUARD_TICKS = 8
) (
    input  logic           clk_adc,
    input  logic           nrst,
    trig_coax_tx_if.slave  bus
);
    localparam int TMAX = (QUIET_TICKS > GUARD_TICKS) ? QUIET_TICKS : GUARD_TICKS;
    localparam int TW   = $clog2(TMAX + 1);

    typedef enum logic [1:0] {IDLE, QUIET, SYNC, GUARD} state_e;

    state_e         state_q, state_d;
    logic [1:0]     phase_q;
    logic [TW-1:0]  tick_q, tick_d;
    logic [5:0]     sync_q, sync_d;
    logic [NCH-1:0] pend_q, pend_d;
    logic [NCH-1:0] coax_q, coax_d;

    always_ff @(posedge clk_adc or negedge nrst) begin
        if (!nrst) begin
            state_q <= IDLE;
            phase_q <= 2'd0;
            tick_q  <= '0;
            sync_q  <= '0;
            pend_q  <= '0;
            coax_q  <= '0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_q + 2'd1;
            tick_q  <= tick_d;
            sync_q  <= sync_d;
            pend_q  <= pend_d;
            coax_q  <= coax_d;
        end
    end

    // Outputs only ever load on the phase==3 cycle, so every pulse lands on phase==0.
    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        sync_d  = sync_q;
        pend_d  = '0;
        coax_d  = '0;
        case (state_q)
            IDLE: begin
                if (phase_q == 2'd3) coax_d = bus.ch_en & (pend_q | bus.trig_in);
                else                 pend_d = pend_q | bus.trig_in;
                if (bus.cal_start) begin
                    state_d = QUIET;
                    tick_d  = '0;
                end
            end
            QUIET: begin
                if (tick_q == TW'(QUIET_TICKS - 1)) begin
                    state_d = SYNC;
                    sync_d  = '0;
                end else begin
                    tick_d = tick_q + 1'b1;
                end
            end
            SYNC: begin
                if (phase_q == 2'd3) begin
                    coax_d = bus.ch_en;
                    if (sync_q == 6'(NSYNC - 1)) begin
                        state_d = GUARD;
                        tick_d  = '0;
                    end else begin
                        sync_d = sync_q + 6'd1;
                    end
                end
            end
            GUARD: begin
                if (tick_q == TW'(GUARD_TICKS - 1)) state_d = IDLE;
                else                                tick_d  = tick_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.coax_out = coax_q;
    assign bus.cal_busy = (state_q != IDLE);
    assign bus.phase    = phase_q;

`ifdef TRIGTX_COUNT_EN
    logic [NCH-1:0][15:0] cnt_q, cnt_d;
    logic [15:0]          cnt_out_q, cnt_out_d;
    logic [NCH-1:0]       inc;

    // Only trigger-path loads count; sync loads happen outside IDLE.
    assign inc = (state_q == IDLE && phase_q == 2'd3) ? coax_d : '0;

    always_comb begin
        cnt_d = cnt_q;
        if (bus.cnt_clr) begin
            cnt_d = '0;
        end else begin
            for (int j = 0; j < NCH; j++)
                if (inc[j] && cnt_q[j] != 16'hFFFF) cnt_d[j] = cnt_q[j] + 16'd1;
        end
        cnt_out_d = '0;
        for (int j = 0; j < NCH; j++)
            if (int'(bus.cnt_sel) == j) cnt_out_d = cnt_q[j];
    end

    always_ff @(posedge clk_adc or negedge nrst) begin
        if (!nrst) begin
            cnt_q     <= '0;
            cnt_out_q <= '0;
        end else begin
            cnt_q     <= cnt_d;
            cnt_out_q <= cnt_out_d;
        end
    end

    assign bus.cnt_out = cnt_out_q;
`else
    logic unused_cnt;
    assign unused_cnt  = ^{bus.cnt_sel, bus.cnt_clr};
    assign bus.cnt_out = 16'd0;
`endif
endmodule

// File: tb/tb_trig_coax_tx.sv
// Bench for trig_coax_tx: directed scenarios plus random traffic against a timeline model
// that predicts pulses from slot boundaries and burst start times.
module tb_trig_coax_tx;
    localparam int NCH = 16;
    localparam int QT  = 250;
    localparam int NS  = 55;
    localparam int GT  = 8;

    logic clk = 1'b0;
    logic nrst = 1'b0;
    always #5 clk = ~clk;

    trig_coax_tx_if #(.NCH(NCH)) bus();

    trig_coax_tx #(.NCH(NCH), .QUIET_TICKS(QT), .NSYNC(NS), .GUARD_TICKS(GT)) dut (
        .clk_adc (clk),
        .nrst    (nrst),
        .bus     (bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Timeline model: e counts clock edges since reset release; the slot boundary
    // falls on edges whose pre-edge phase is 3; a burst started at edge e0 owns edges
    // e0+1 .. eL+GT, with sync loads every 4 edges from e1 to eL.
    int             e, e0, e1, eL;
    bit             bursting;
    logic [NCH-1:0] acc;
    int unsigned    cnt_m [NCH];
    int             pc [NCH];

    task automatic model_reset();
        e = 0; e0 = 0; e1 = 0; eL = 0;
        bursting = 1'b0;
        acc = '0;
        for (int j = 0; j < NCH; j++) cnt_m[j] = 0;
    endtask

    task automatic clr_pc();
        for (int j = 0; j < NCH; j++) pc[j] = 0;
    endtask

    task automatic step();
        logic [NCH-1:0] trig, en, exp_coax;
        logic           cal, clr, idle_edge;
        logic [3:0]     sel;
        logic [15:0]    exp_cnt;
        int             pp;
        trig = bus.trig_in; en = bus.ch_en; cal = bus.cal_start;
        clr  = bus.cnt_clr; sel = bus.cnt_sel;
        @(posedge clk);
        e++;
        pp = (e - 1) % 4;
        exp_coax = '0;
        idle_edge = 1'b0;
`ifdef TRIGTX_COUNT_EN
        exp_cnt = 16'(cnt_m[sel]);
`else
        exp_cnt = 16'd0;
`endif
        if (bursting && e > e0) begin
            if (e >= e1 && e <= eL && (e - e1) % 4 == 0) exp_coax = en;
            acc = '0;
            if (e == eL + GT) bursting = 1'b0;
        end else begin
            idle_edge = 1'b1;
            if (pp == 3) begin
                exp_coax = en & (acc | trig);
                acc = '0;
            end else begin
                acc |= trig;
            end
            if (cal) begin
                bursting = 1'b1;
                e0 = e;
                e1 = e0 + QT + 1;
                while ((e1 - 1) % 4 != 3) e1++;
                eL = e1 + 4 * (NS - 1);
            end
        end
        for (int j = 0; j < NCH; j++) begin
            if (clr) cnt_m[j] = 0;
            else if (idle_edge && exp_coax[j] && cnt_m[j] < 32'hFFFF) cnt_m[j]++;
        end
        #1;
        chk("coax", 32'(bus.coax_out), 32'(exp_coax));
        chk("busy", 32'(bus.cal_busy), 32'(bursting));
        chk("phase", 32'(bus.phase), 32'(e % 4));
        chk("cnt_out", 32'(bus.cnt_out), 32'(exp_cnt));
        for (int j = 0; j < NCH; j++) if (bus.coax_out[j]) pc[j]++;
    endtask

    // Advance until the next edge has pre-edge phase 0 (bounded).
    task automatic align0();
        for (int i = 0; i < 4 && bus.phase != 2'd0; i++) step();
        chk("align", 32'(bus.phase), 32'd0);
    endtask

    task automatic run_burst(output int len, output int first);
        len = 1; first = -1;
        bus.cal_start = 1'b1;
        step();
        bus.cal_start = 1'b0;
        clr_pc();
        for (int i = 0; i < 700; i++) begin
            step();
            len++;
            if (first < 0 && bus.coax_out != '0) first = len;
            if (!bus.cal_busy) break;
        end
        chk("burst_ends", 32'(bus.cal_busy), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int len, first, others, exp10;
        bus.trig_in = '0; bus.ch_en = '1; bus.cal_start = 1'b0;
        bus.cnt_sel = 4'd0; bus.cnt_clr = 1'b0;
        model_reset();
        clr_pc();
        #22;
        chk("rst_coax", 32'(bus.coax_out), 32'd0);
        chk("rst_busy", 32'(bus.cal_busy), 32'd0);
        chk("rst_phase", 32'(bus.phase), 32'd0);
        chk("rst_cnt", 32'(bus.cnt_out), 32'd0);
        @(posedge clk); #1;
        nrst = 1'b1;
        model_reset();

        // Held trigger on channel 2 for 20 cycles from reset release.
        bus.trig_in = 16'h0004;
        repeat (20) step();
        bus.trig_in = '0;
        repeat (4) step();
        others = 0;
        for (int j = 0; j < NCH; j++) if (j != 2) others += pc[j];
        chk("held_ch2", 32'(pc[2]), 32'd5);
        chk("held_other", 32'(others), 32'd0);

        // Two requests in one slot merge into one pulse at phase 0.
        align0();
        clr_pc();
        bus.trig_in = 16'h0020; step();
        bus.trig_in = '0;       step();
        bus.trig_in = 16'h0020; step();
        bus.trig_in = '0;       step();
        chk("merge_at_ph0", {29'd0, bus.phase, bus.coax_out[5]}, 32'd1);
        repeat (8) step();
        chk("merge_cnt", 32'(pc[5]), 32'd1);

        // Calibration burst with only the low byte enabled.
        bus.ch_en = 16'h00FF;
        repeat (4) step();
        run_burst(len, first);
        chk("burst_len", 32'(len <= 481), 32'd1);
        chk("quiet_len", 32'(first > 250), 32'd1);
        chk("sync_ch0", 32'(pc[0]), 32'(NS));
        chk("sync_ch7", 32'(pc[7]), 32'(NS));
        chk("sync_ch8", 32'(pc[8]), 32'd0);

        // Triggers held through a burst are discarded; pulsing resumes after.
        bus.ch_en = '1;
        bus.trig_in = '1;
        run_burst(len, first);
        chk("trigcal_ch0", 32'(pc[0]), 32'(NS));
        chk("trigcal_ch15", 32'(pc[15]), 32'(NS));
        clr_pc();
        repeat (16) step();
        chk("resume_ch0", 32'(pc[0]), 32'd4);
        bus.trig_in = '0;
        repeat (4) step();

        // Asynchronous reset in the middle of the sync train.
        bus.cal_start = 1'b1;
        step();
        bus.cal_start = 1'b0;
        clr_pc();
        for (int i = 0; i < 600 && pc[0] < 20; i++) step();
        chk("midsync_reached", 32'(pc[0]), 32'd20);
        #2 nrst = 1'b0;
        #1;
        chk("arst_coax", 32'(bus.coax_out), 32'd0);
        chk("arst_busy", 32'(bus.cal_busy), 32'd0);
        chk("arst_phase", 32'(bus.phase), 32'd0);
        @(posedge clk); #1;
        nrst = 1'b1;
        model_reset();
        run_burst(len, first);
        chk("after_rst_sync", 32'(pc[0]), 32'(NS));

        // Sent-pulse counters: 10 trigger pulses on channel 3 plus a burst.
        bus.cnt_sel = 4'd3;
        bus.cnt_clr = 1'b1; step();
        bus.cnt_clr = 1'b0;
        align0();
        bus.trig_in = 16'h0008;
        repeat (40) step();
        bus.trig_in = '0;
        run_burst(len, first);
        repeat (2) step();
`ifdef TRIGTX_COUNT_EN
        exp10 = 10;
`else
        exp10 = 0;
`endif
        chk("cnt_ch3", 32'(bus.cnt_out), 32'(exp10));
        bus.cnt_clr = 1'b1; step();
        bus.cnt_clr = 1'b0; step();
        chk("cnt_clr", 32'(bus.cnt_out), 32'd0);

        // Random traffic with occasional bursts and clears.
        for (int i = 0; i < 2000; i++) begin
            bus.trig_in   = 16'($urandom & $urandom & $urandom);
            bus.ch_en     = 16'($urandom);
            bus.cal_start = ($urandom_range(0, 299) == 0);
            bus.cnt_sel   = 4'($urandom);
            bus.cnt_clr   = ($urandom_range(0, 63) == 0);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
